t_seq_loader: RTL

- Receive side of the T-sequence load protocol inside the Smith-Waterman top level.
- Accepts the packed 18-bit T word stream that follows a `set_t` pulse and writes each word into the T SRAM.
- Computes the T length in bases.
- Replays the stored sequence as a 2-bit base stream, with a ready/valid handshake, for the PE-array feeder.

---
 rtl/t_seq_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/t_seq_loader.sv
// Receive side of the T-sequence load protocol: writes packed T words into the T SRAM,
// tracks the length in bases and replays the stored sequence as a ready/valid base stream.
module t_seq_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_t,
  input  logic [17:0]       i_t,
  output logic              o_busy,
  output logic [ADDR_W+2:0] o_len,
  output logic              o_len_valid,
  output logic              o_overflow,
  output logic              o_sram_we,
  output logic              o_sram_re,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [13:0]       o_sram_wdata,
  input  logic [13:0]       i_sram_rdata,
  input  logic              i_rd_start,
  input  logic              i_rd_ready,
  output logic [1:0]        o_base,
  output logic              o_base_valid,
  output logic              o_base_last
);

  localparam int unsigned LenW = ADDR_W + 3;

  typedef enum logic [2:0] {StIdle, StRecv, StDone, StFetch, StWait, StStream} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LenW-1:0]   len_q;
  logic              len_valid_q;
  logic              overflow_q;
  logic [13:0]       shift_q;
  logic [2:0]        cnt_q;
  logic              last_word_q;

  logic [2:0]      k;
  logic [LenW-1:0] addr_x7;
  logic [LenW-1:0] rem;
  logic            rem_le7;
  logic            t_unused;

  assign k        = i_t[16:14];
  assign t_unused = i_t[17];

  // 7 * addr, shared by the length computation (word counter) and replay (read address)
  assign addr_x7 = ({3'b000, addr_q} << 3) - {3'b000, addr_q};
  assign rem     = len_q - addr_x7;
  assign rem_le7 = (rem <= LenW'(7));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      len_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      last_word_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (i_set_t) begin
            state_q     <= StRecv;
            len_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            addr_q      <= '0;
          end else if (state_q == StDone && i_rd_start) begin
            state_q <= StFetch;
            addr_q  <= '0;
          end
        end
        StRecv: begin
          if (k != 3'd0) begin
            len_q       <= addr_x7 + LenW'(k);
            len_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (addr_q == '1) begin
            // Full word at the last address: 7*n + 7 = 7 * 2^ADDR_W
            len_q       <= addr_x7 + LenW'(7);
            len_valid_q <= 1'b1;
            overflow_q  <= 1'b1;
            state_q     <= StDone;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        StFetch: begin
          state_q <= (len_q == '0) ? StIdle : StWait;
        end
        StWait: begin
          shift_q     <= i_sram_rdata;
          cnt_q       <= rem_le7 ? rem[2:0] : 3'd7;
          last_word_q <= rem_le7;
          state_q     <= StStream;
        end
        StStream: begin
          if (i_rd_ready) begin
            shift_q <= shift_q >> 2;
            cnt_q   <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              if (last_word_q) begin
                state_q <= StDone;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= StFetch;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy       = (state_q == StRecv) || (state_q == StFetch) ||
                        (state_q == StWait) || (state_q == StStream);
  assign o_len        = len_q;
  assign o_len_valid  = len_valid_q;
  assign o_overflow   = overflow_q;
  assign o_sram_we    = (state_q == StRecv);
  assign o_sram_re    = (state_q == StFetch);
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = i_t[13:0];
  assign o_base_valid = (state_q == StStream);
  assign o_base       = o_base_valid ? shift_q[1:0] : 2'b00;
  assign o_base_last  = o_base_valid && last_word_q && (cnt_q == 3'd1);

endmodule
